// File: rtl/rs_alu.sv
// rs_alu: single-cycle RV32I integer execution unit feeding the CDB, with JALR redirect to fetch
module rs_alu #(
    parameter int VAL_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int OP_WIDTH     = 7,
    parameter int ROB_ID_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush,
    input  logic                    execute,
    input  logic [OP_WIDTH-1:0]     op_type,
    input  logic [VAL_WIDTH-1:0]    val1,
    input  logic [VAL_WIDTH-1:0]    val2,
    input  logic [ROB_ID_WIDTH:0]   entry,
    input  logic [ADDR_WIDTH-1:0]   nowPC,
    output logic                    aluReady,
    output logic [ROB_ID_WIDTH:0]   entry_out,
    output logic [VAL_WIDTH-1:0]    val_out,
    output logic [ADDR_WIDTH-1:0]   alu2if_pc,
    output logic                    alu2if_con
);
    localparam int SH = $clog2(VAL_WIDTH);
    localparam logic [2:0] C_R = 3'd1, C_I = 3'd2, C_B = 3'd3, C_M = 3'd4;

    logic [2:0]           cls;
    logic [3:0]           op;
    logic [SH-1:0]        sh;
    logic [VAL_WIDTH-1:0] sum, diff, sll_v, srl_v, sra_v, target, res;
    logic                 eq, lt, ltu, jalr;
    logic                 unused_ok;

    assign cls    = op_type[6:4];
    assign op     = op_type[3:0];
    assign sh     = val2[SH-1:0];
    assign sum    = val1 + val2;
    assign diff   = val1 - val2;
    assign sll_v  = val1 << sh;
    assign srl_v  = val1 >> sh;
    assign sra_v  = $signed(val1) >>> sh;
    assign target = sum & ~VAL_WIDTH'(1);
    assign eq     = val1 == val2;
    assign lt     = $signed(val1) < $signed(val2);
    assign ltu    = val1 < val2;
    assign unused_ok = ^nowPC;

    always_comb begin
        res  = '0;
        jalr = 1'b0;
        case (cls)
            C_R: case (op)
                4'd0: res = sum;
                4'd1: res = diff;
                4'd2: res = sll_v;
                4'd3: res = VAL_WIDTH'(lt);
                4'd4: res = VAL_WIDTH'(ltu);
                4'd5: res = val1 ^ val2;
                4'd6: res = srl_v;
                4'd7: res = sra_v;
                4'd8: res = val1 | val2;
                4'd9: res = val1 & val2;
                default: res = '0;
            endcase
            C_I: case (op)
                4'd0: res = sum;
                4'd1: res = VAL_WIDTH'(lt);
                4'd2: res = VAL_WIDTH'(ltu);
                4'd3: res = val1 ^ val2;
                4'd4: res = val1 | val2;
                4'd5: res = val1 & val2;
                4'd6: res = sll_v;
                4'd7: res = srl_v;
                4'd8: res = sra_v;
                4'd9: begin
                    res  = target;
                    jalr = 1'b1;
                end
                default: res = '0;
            endcase
            C_B: case (op)
                4'd0: res = VAL_WIDTH'(eq);
                4'd1: res = VAL_WIDTH'(!eq);
                4'd2: res = VAL_WIDTH'(lt);
                4'd3: res = VAL_WIDTH'(!lt);
                4'd4: res = VAL_WIDTH'(ltu);
                4'd5: res = VAL_WIDTH'(!ltu);
                default: res = '0;
            endcase
            // LUI arrives with val2 = 0, so all three misc ops reduce to a sum
            C_M: res = (op <= 4'd2) ? sum : '0;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in || (flush && rdy_in)) begin
            aluReady   <= 1'b0;
            entry_out  <= '0;
            val_out    <= '0;
            alu2if_pc  <= '0;
            alu2if_con <= 1'b0;
        end else if (rdy_in) begin
            aluReady   <= execute;
            alu2if_con <= execute && jalr;
            if (execute) begin
                entry_out <= entry;
                val_out   <= res;
                if (jalr) alu2if_pc <= ADDR_WIDTH'(target);
            end
        end
    end
endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: directed scoreboard bench for rs_alu
module tb_rs_alu;
    logic        clk = 1'b0;
    logic        rst_in, rdy_in, flush, execute;
    logic [6:0]  op_type;
    logic [31:0] val1, val2, nowPC;
    logic [4:0]  entry;
    logic        aluReady, alu2if_con;
    logic [4:0]  entry_out;
    logic [31:0] val_out, alu2if_pc;

    typedef struct packed {
        logic [4:0]  e;
        logic [31:0] v;
        logic        con;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_pc = '0;

    always #5 clk = ~clk;

    rs_alu dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .execute(execute),
        .op_type(op_type), .val1(val1), .val2(val2), .entry(entry), .nowPC(nowPC),
        .aluReady(aluReady), .entry_out(entry_out), .val_out(val_out),
        .alu2if_pc(alu2if_pc), .alu2if_con(alu2if_con)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag);
        exp_t x;
        chk({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk({tag, "_rdy"}, 32'(aluReady), 32'd1);
            chk({tag, "_entry"}, 32'(entry_out), 32'(x.e));
            chk({tag, "_val"}, val_out, x.v);
            chk({tag, "_con"}, 32'(alu2if_con), 32'(x.con));
            chk({tag, "_pc"}, alu2if_pc, x.pc);
        end
    endtask

    task automatic issue(input string tag, input logic [6:0] t, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] e, input logic [31:0] v);
        execute = 1'b1;
        op_type = t;
        val1    = a;
        val2    = b;
        entry   = e;
        if (t == 7'h29) m_pc = v;
        sb.push_back('{e, v, (t == 7'h29), m_pc});
        tick;
        execute = 1'b0;
        pop_check(tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"}, 32'(aluReady), 32'd0);
        chk({tag, "_con"}, 32'(alu2if_con), 32'd0);
        chk({tag, "_val"}, val_out, 32'd0);
        chk({tag, "_entry"}, 32'(entry_out), 32'd0);
        chk({tag, "_pc"}, alu2if_pc, 32'd0);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; execute = 1'b0;
        op_type = '0; val1 = '0; val2 = '0; entry = '0; nowPC = 32'hdead_0000;
        tick;
        tick;
        chk_zero("reset");
        rst_in = 1'b0;

        issue("add", 7'h10, 32'd5, 32'd7, 5'd3, 32'd12);
        tick;
        chk("idle_rdy", 32'(aluReady), 32'd0);
        chk("idle_val", val_out, 32'd12);
        chk("idle_entry", 32'(entry_out), 32'd3);

        issue("slt",   7'h13, 32'hffff_ffff, 32'd1, 5'd1, 32'd1);
        issue("sltu",  7'h14, 32'hffff_ffff, 32'd1, 5'd2, 32'd0);
        issue("sra",   7'h17, 32'h8000_0000, 32'd4, 5'd3, 32'hf800_0000);
        issue("srl",   7'h16, 32'h8000_0000, 32'd4, 5'd4, 32'h0800_0000);
        issue("sub",   7'h11, 32'd5, 32'd7, 5'd5, 32'hffff_fffe);
        issue("sll",   7'h12, 32'd1, 32'd33, 5'd6, 32'd2);
        issue("xor",   7'h15, 32'h0000_f0f0, 32'h0000_00ff, 5'd7, 32'h0000_f00f);
        issue("or",    7'h18, 32'h0000_00f0, 32'h0000_000f, 5'd8, 32'h0000_00ff);
        issue("and",   7'h19, 32'h0000_00f0, 32'h0000_003c, 5'd9, 32'h0000_0030);
        issue("addi",  7'h20, 32'hffff_ffff, 32'd1, 5'd10, 32'd0);
        issue("sltiu", 7'h22, 32'd1, 32'hffff_ffff, 5'd11, 32'd1);
        issue("srai",  7'h28, 32'h8000_0000, 32'd31, 5'd12, 32'hffff_ffff);

        issue("beq",   7'h30, 32'd9, 32'd9, 5'd13, 32'd1);
        issue("bne",   7'h31, 32'd9, 32'd9, 5'd14, 32'd0);
        issue("bge",   7'h33, 32'hffff_ffff, 32'd0, 5'd15, 32'd0);
        issue("bgeu",  7'h35, 32'hffff_ffff, 32'd0, 5'd16, 32'd1);
        issue("blt",   7'h32, 32'hffff_ffff, 32'd0, 5'd17, 32'd1);
        issue("bltu",  7'h34, 32'hffff_ffff, 32'd0, 5'd18, 32'd0);

        issue("lui",   7'h40, 32'h1234_5000, 32'd0, 5'd19, 32'h1234_5000);
        issue("auipc", 7'h41, 32'h0000_1000, 32'h0000_2000, 5'd20, 32'h0000_3000);
        issue("jal",   7'h42, 32'd4, 32'h0000_0100, 5'd21, 32'h0000_0104);
        issue("undef_r", 7'h1a, 32'd5, 32'd5, 5'd22, 32'd0);
        issue("undef_c", 7'h70, 32'd5, 32'd5, 5'd23, 32'd0);

        issue("jalr",  7'h29, 32'h0000_1003, 32'd4, 5'd6, 32'h0000_1006);
        tick;
        chk("jalr_drop_con", 32'(alu2if_con), 32'd0);
        chk("jalr_drop_rdy", 32'(aluReady), 32'd0);
        chk("jalr_hold_pc", alu2if_pc, 32'h0000_1006);

        issue("add2", 7'h10, 32'd1, 32'd2, 5'd5, 32'd3);
        rdy_in  = 1'b0;
        execute = 1'b1;
        op_type = 7'h10; val1 = 32'd100; val2 = 32'd100; entry = 5'd9;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 2);
            tick;
            chk("stall_rdy", 32'(aluReady), 32'd1);
            chk("stall_val", val_out, 32'd3);
            chk("stall_entry", 32'(entry_out), 32'd5);
        end
        rdy_in = 1'b1;
        flush  = 1'b1;
        tick;
        flush   = 1'b0;
        execute = 1'b0;
        m_pc    = '0;
        chk_zero("flush");

        issue("add3", 7'h10, 32'd2, 32'd2, 5'd4, 32'd4);
        rst_in  = 1'b1;
        execute = 1'b1;
        op_type = 7'h29; val1 = 32'h0000_2000; val2 = 32'd0; entry = 5'd7;
        tick;
        rst_in  = 1'b0;
        execute = 1'b0;
        chk_zero("rst_prio");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
